// File: rtl/boton_pulso.sv
// Push-button conditioner: synchronizer, debounce FSM and auto-repeat.
// Emits one-cycle count-enable strobes for a downstream counter.
module boton_pulso #(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned AUTO_DELAY  = 8,
    parameter int unsigned AUTO_PERIOD = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic en_pulse,
    output logic btn_level,
    output logic repeating
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
    localparam logic [15:0] DLY_LAST =
        (AUTO_DELAY == 0) ? 16'd0 : 16'(AUTO_DELAY - 1);
    localparam logic [15:0] REP_LAST = 16'(AUTO_PERIOD - 1);
    localparam logic        AUTO_ON  = (AUTO_DELAY != 0);

    state_t      state;
    state_t      state_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic [15:0] cnt_inc;
    logic        sync1;
    logic        btn_s;
    logic        pulse_nx;

    // Two-flop synchronizer for the raw asynchronous button level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn_in;
            btn_s <= sync1;
        end
    end

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    // Next-state, shared counter and pulse decision.
    // A pulse due while en_pulse is still high is held off one cycle
    // (cnt frozen) so strobes are never back to back.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_inc;
        pulse_nx = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = 16'd0;
                if (btn_s) state_nx = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_nx = HELD;
                    pulse_nx = 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nx = RELEASE_WAIT;
                end else if (AUTO_ON && cnt == DLY_LAST) begin
                    if (!en_pulse) begin
                        state_nx = REPEAT;
                        pulse_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt;
                    end
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_nx = RELEASE_WAIT;
                end else if (cnt == REP_LAST) begin
                    if (!en_pulse) begin
                        pulse_nx = 1'b1;
                        cnt_nx   = 16'd0;
                    end else begin
                        cnt_nx = cnt;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_nx = HELD;
                end else if (cnt == DEB_LAST) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 16'd0;
            end
        endcase
        if (state_nx != state) cnt_nx = 16'd0;
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            en_pulse  <= 1'b0;
            btn_level <= 1'b0;
            repeating <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            en_pulse  <= pulse_nx;
            btn_level <= (state_nx == HELD) || (state_nx == REPEAT)
                         || (state_nx == RELEASE_WAIT);
            repeating <= (state_nx == REPEAT);
        end
    end

endmodule

// File: tb/tb_boton_pulso.sv
// Directed bench for boton_pulso: debounce, auto-repeat, reset, counter.
// Edge numbers are counted from the first edge of each scenario.
module tb_boton_pulso;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b0;
    logic       en_pulse;
    logic       btn_level;
    logic       repeating;
    logic       en2;
    logic       lvl2;
    logic       rep2;
    logic       q_clr = 1'b0;
    logic [3:0] q4;
    int         checks = 0;
    int         failures = 0;

    boton_pulso dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .en_pulse(en_pulse),
        .btn_level(btn_level),
        .repeating(repeating)
    );

    boton_pulso #(
        .DEB_CYCLES(1),
        .AUTO_DELAY(1),
        .AUTO_PERIOD(1)
    ) dut2 (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .en_pulse(en2),
        .btn_level(lvl2),
        .repeating(rep2)
    );

    always #5 clk = ~clk;

    // Downstream 4-bit counter fed by the strobe.
    always_ff @(posedge clk) begin
        if (q_clr) q4 <= 4'd0;
        else if (en_pulse) q4 <= q4 + 4'd1;
    end

    task automatic step(input logic b);
        btn_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        for (int i = 0; i < 12; i++) step(1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(1'b1);
        step(1'b1);
        checks++;
        if ({en_pulse, btn_level, repeating} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000",
                     {en_pulse, btn_level, repeating});
        end
        rst = 1'b1;
        go_idle();
    endtask

    task automatic test_clean_press();
        logic b;
        for (int e = 1; e <= 22; e++) begin
            b = (e <= 12);
            step(b);
            checks++;
            if (en_pulse !== (e == 7) ||
                btn_level !== (e >= 7 && e < 19) ||
                repeating !== 1'b0) begin
                failures++;
                $display("FAIL clean_press e=%0d got=%b%b%b want=%b%b0",
                         e, en_pulse, btn_level, repeating,
                         (e == 7), (e >= 7 && e < 19));
            end
        end
        go_idle();
    endtask

    task automatic test_bounce();
        logic b;
        for (int e = 1; e <= 24; e++) begin
            b = (e <= 3) || (e >= 5 && e <= 14);
            step(b);
            checks++;
            if (en_pulse !== (e == 11) ||
                btn_level !== (e >= 11 && e < 21)) begin
                failures++;
                $display("FAIL bounce e=%0d got=%b%b want=%b%b",
                         e, en_pulse, btn_level,
                         (e == 11), (e >= 11 && e < 21));
            end
        end
        go_idle();
    endtask

    task automatic test_auto_repeat();
        logic b;
        logic exp_p;
        int   npulse;
        npulse = 0;
        for (int e = 1; e <= 40; e++) begin
            b = (e <= 30);
            step(b);
            exp_p = (e == 7) || (e == 15) || (e == 18) || (e == 21) ||
                    (e == 24) || (e == 27) || (e == 30);
            if (en_pulse === 1'b1) npulse++;
            checks++;
            if (en_pulse !== exp_p ||
                repeating !== (e >= 15 && e < 33) ||
                btn_level !== (e >= 7 && e < 37)) begin
                failures++;
                $display("FAIL auto_repeat e=%0d got=%b%b%b want=%b%b%b",
                         e, en_pulse, btn_level, repeating, exp_p,
                         (e >= 7 && e < 37), (e >= 15 && e < 33));
            end
        end
        checks++;
        if (npulse != 7) begin
            failures++;
            $display("FAIL auto_repeat_count got=%0d want=7", npulse);
        end
        go_idle();
    endtask

    task automatic test_release_bounce();
        logic b;
        int   i;
        for (int e = 1; e <= 26; e++) begin
            i = e - 9;
            if (e <= 8) b = 1'b1;
            else if (e <= 18) b = ((i / 2) % 2) == 1;
            else b = 1'b0;
            step(b);
            checks++;
            if (en_pulse !== (e == 7) ||
                btn_level !== (e >= 7 && e < 23)) begin
                failures++;
                $display("FAIL release_bounce e=%0d got=%b%b want=%b%b",
                         e, en_pulse, btn_level,
                         (e == 7), (e >= 7 && e < 23));
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid_repeat();
        for (int e = 1; e <= 20; e++) step(1'b1);
        checks++;
        if (repeating !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_repeating got=%b want=1", repeating);
        end
        rst = 1'b0;
        step(1'b1);
        rst = 1'b1;
        checks++;
        if ({en_pulse, btn_level, repeating} !== 3'b000) begin
            failures++;
            $display("FAIL mid_repeat_reset got=%b want=000",
                     {en_pulse, btn_level, repeating});
        end
        for (int n = 1; n <= 10; n++) begin
            step(1'b1);
            checks++;
            if (en_pulse !== (n == 7) || btn_level !== (n >= 7) ||
                repeating !== 1'b0) begin
                failures++;
                $display("FAIL after_reset n=%0d got=%b%b%b want=%b%b0",
                         n, en_pulse, btn_level, repeating,
                         (n == 7), (n >= 7));
            end
        end
        go_idle();
    endtask

    task automatic test_period_one();
        logic exp_p;
        for (int e = 1; e <= 12; e++) begin
            step(1'b1);
            exp_p = (e >= 4) && (e % 2 == 0);
            checks++;
            if (en2 !== exp_p || rep2 !== (e >= 6) ||
                lvl2 !== (e >= 4)) begin
                failures++;
                $display("FAIL period_one e=%0d got=%b%b%b want=%b%b%b",
                         e, en2, lvl2, rep2, exp_p, (e >= 4), (e >= 6));
            end
        end
        go_idle();
    endtask

    task automatic test_counter();
        q_clr = 1'b1;
        step(1'b0);
        q_clr = 1'b0;
        for (int p = 1; p <= 17; p++) begin
            for (int i = 0; i < 8; i++) step(1'b1);
            for (int i = 0; i < 10; i++) step(1'b0);
            if (p == 16) begin
                checks++;
                if (q4 !== 4'd0) begin
                    failures++;
                    $display("FAIL counter_16 got=%b want=0000", q4);
                end
            end
        end
        checks++;
        if (q4 !== 4'b0001) begin
            failures++;
            $display("FAIL counter_17 got=%b want=0001", q4);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_bounce();
        test_reset_mid_repeat();
        test_period_one();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boton_pulso.md
BOTON_PULSO -- requirements
Module: boton_pulso

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive synchronized-stable cycles required to accept a press or a release; legal range 1..65535.
REQ-002 Parameter AUTO_DELAY, default 8: hold cycles after the first pulse before auto-repeat starts; 0 disables auto-repeat; legal range 0..65535.
REQ-003 Parameter AUTO_PERIOD, default 3: cycles between auto-repeat pulses; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-low: rst=0 sampled at a rising clk edge resets the block.
REQ-006 btn_in  input  1  raw asynchronous push-button level; 1 = pressed.
REQ-007 en_pulse  output  1  one-cycle count-enable strobe, driven directly into the 4-bit counter's en input.
REQ-008 btn_level  output  1  debounced button level.
REQ-009 repeating  output  1  high while the block is in auto-repeat.

Function
REQ-010 btn_in SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second-flop output btn_s.
REQ-011 The FSM SHALL have exactly five states: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT.
REQ-012 One 16-bit unsigned counter cnt SHALL be shared by all states; it SHALL clear to 0 on every state change and saturate, never wrap.
REQ-013 IDLE with btn_s=1: the FSM SHALL go to PRESS_WAIT; with btn_s=0 it SHALL stay in IDLE.
REQ-014 PRESS_WAIT with btn_s=0: the FSM SHALL return to IDLE with no pulse (glitch rejected).
REQ-015 PRESS_WAIT with btn_s=1 and cnt==DEB_CYCLES-1: the FSM SHALL go to HELD and assert en_pulse for exactly the next cycle; otherwise cnt SHALL increment.
REQ-016 Press latency: en_pulse SHALL rise after rising edge DEB_CYCLES+3, counting the first edge that samples btn_in=1 as edge 1.
REQ-017 HELD with btn_s=0: the FSM SHALL go to RELEASE_WAIT.
REQ-018 HELD with btn_s=1, AUTO_DELAY!=0 and cnt==AUTO_DELAY-1: the FSM SHALL go to REPEAT and pulse once; otherwise cnt SHALL increment.
REQ-019 REPEAT with btn_s=1: cnt SHALL increment, and at cnt==AUTO_PERIOD-1 the block SHALL pulse once and clear cnt.
REQ-020 REPEAT with btn_s=0: the FSM SHALL go to RELEASE_WAIT.
REQ-021 RELEASE_WAIT with btn_s=1: the FSM SHALL go to HELD with cnt=0 and no pulse (bounce on release never double-counts).
REQ-022 RELEASE_WAIT with btn_s=0 and cnt==DEB_CYCLES-1: the FSM SHALL go to IDLE; otherwise cnt SHALL increment.
REQ-023 Simultaneous events: btn_s=0 SHALL take priority over any pulse condition in the same cycle, so no pulse is issued.
REQ-024 en_pulse SHALL never be high for two consecutive cycles; with AUTO_PERIOD=1 the pulses SHALL be one cycle high, one cycle low.
REQ-025 btn_level SHALL be 1 in HELD, REPEAT and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
REQ-026 repeating SHALL be 1 only in REPEAT.
REQ-027 All outputs SHALL be registered, with no combinational path from btn_in to any output.

Reset
REQ-028 On rst=0 at a clk edge, the block SHALL set: FSM=IDLE, cnt=0, both synchronizer flops=0, en_pulse=0, btn_level=0, repeating=0.
REQ-029 Reset SHALL take priority over every other condition, including mid-debounce and mid-repeat.
REQ-030 After rst returns to 1, a held button SHALL be treated as a new press and pay the full REQ-016 latency.
REQ-031 No pulse SHALL be emitted in the cycle rst is sampled low.

Verification (DEB_CYCLES=4, AUTO_DELAY=8, AUTO_PERIOD=3)
REQ-032 Clean press: btn_in 0->1 before edge 1 and held for 12 cycles -> a single en_pulse after edge 7, btn_level=1 from edge 7, no second pulse before edge 15.
REQ-033 Bounce: btn_in high for 3 cycles, low for 1, then stable high -> no pulse from the short burst, and exactly one pulse DEB_CYCLES+3 edges after the stable rise.
REQ-034 Auto-repeat: hold for 30 cycles -> pulses after edges 7, 15, 18, 21, 24, 27 (subject to the hold length), repeating=1 from edge 15, total pulses matching the hold length.
REQ-035 Release bounce: after a press, btn_in toggles 1/0 every 2 cycles for 10 cycles, then goes low -> no extra pulses, and btn_level falls 4 stable-low cycles after btn_s settles low.
REQ-036 Reset mid-repeat: assert rst=0 for 1 cycle while repeating -> all outputs 0 on the next cycle; the still-held button yields its next pulse 7 edges after rst=1.
REQ-037 Integration: connect en_pulse to the 4-bit counter's en and apply 17 clean press/release cycles -> counter Q=4'b0001 (wrap-around).
